// File: rtl/spi_mult_master.sv
`default_nettype none
// ============================================================================
//  Module   : spi_mult_master
//  Purpose  : Host-side SPI controller for the multiplier peripheral. Sends
//             the operand byte {b,a} MSB first, idles for a fixed number of
//             clocks while the peripheral multiplies, then reads the 8-bit
//             product back.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_mult_master #(
  parameter int CLKDIV      = 8,   // SCLK half-period in clk cycles (>= 2)
  parameter int WAIT_CYCLES = 16   // SCLK-low gap between write and read (>= 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       miso,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  output logic [7:0] result,
  output logic       busy,
  output logic       done
);

  localparam int c_div_w  = $clog2(CLKDIV);
  localparam int c_wait_w = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(CLKDIV - 1);
  localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_WRITE  = 3'd2,
    S_WAIT   = 3'd3,
    S_READ   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t                r_state;
  logic [c_div_w-1:0]    r_div_cnt;
  logic [2:0]            r_bit_cnt;
  logic [c_wait_w-1:0]   r_wait_cnt;
  logic [7:0]            r_tx;
  logic [7:0]            r_rx;

  logic w_div_last;

  // Last clk of the current SCLK half-period (or of the setup interval)
  assign w_div_last = (r_div_cnt == c_div_last);

  // Transfer sequencer: state, counters, shift registers and all outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_div_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_wait_cnt <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      sclk       <= 1'b0;
      cs         <= 1'b1;
      mosi       <= 1'b0;
      result     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          cs   <= 1'b1;
          sclk <= 1'b0;
          if (start) begin
            // Operands are captured here only; later input changes are ignored
            r_tx      <= {b, a};
            mosi      <= b[3];
            cs        <= 1'b0;
            busy      <= 1'b1;
            r_div_cnt <= '0;
            r_state   <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (w_div_last) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_state   <= S_WRITE;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end

        S_WRITE, S_READ: begin
          if (!w_div_last) begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end else begin
            r_div_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              // End of a high phase: SCLK falls, data moves on this edge
              sclk <= 1'b0;
              if (r_state == S_READ) begin
                r_rx <= {r_rx[6:0], miso};
              end
              if (r_bit_cnt == 3'd7) begin
                if (r_state == S_WRITE) begin
                  mosi       <= 1'b0;
                  r_wait_cnt <= '0;
                  r_state    <= S_WAIT;
                end else begin
                  result  <= {r_rx[6:0], miso};
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= S_FINISH;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                if (r_state == S_WRITE) begin
                  r_tx <= {r_tx[6:0], 1'b0};
                  mosi <= r_tx[6];
                end
              end
            end
          end
        end

        S_WAIT: begin
          if (r_wait_cnt == c_wait_last) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_state   <= S_READ;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        S_FINISH: begin
          // Deselect; a new start is accepted from the following cycle
          cs      <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_mult_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_mult_master
//  Purpose  : Self-checking bench for spi_mult_master with a behavioural
//             multiplier peripheral and a result scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_mult_master;

  localparam int CLKDIV      = 8;
  localparam int WAIT_CYCLES = 16;
  localparam int LATENCY     = CLKDIV + 16*CLKDIV + WAIT_CYCLES + 16*CLKDIV + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       miso = 1'b0;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic [7:0] result;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  logic [7:0] sb[$];

  // behavioural peripheral state
  logic       sclk_q = 1'b0;
  logic       cs_q   = 1'b1;
  int         slv_cnt = 0;
  int         slv_gap = 0;
  int         mosi_err = 0;
  logic [7:0] slv_wr = '0;
  logic [7:0] slv_p  = '0;

  spi_mult_master #(.CLKDIV(CLKDIV), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .miso(miso),
    .sclk(sclk), .cs(cs), .mosi(mosi), .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard on done, plus the peripheral model, all sampled mid-cycle
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (sb.size() == 0) check_eq("spurious_done", 32'd1, 32'd0);
      else                check_eq("result", {24'd0, result}, {24'd0, sb.pop_front()});
    end
    if (cs || reset) miso = 1'b0;
    if (cs_q && !cs) begin
      slv_cnt = 0;
      slv_wr  = '0;
      slv_gap = 0;
    end
    if (!cs && !reset) begin
      if (sclk && !sclk_q) begin
        if (slv_cnt < 8) slv_wr = {slv_wr[6:0], mosi};
        slv_cnt++;
        if (slv_cnt == 8) begin
          slv_p = 8'(slv_wr[7:4]) * 8'(slv_wr[3:0]);
          miso  = slv_p[7];
        end
      end else if (!sclk && sclk_q && slv_cnt >= 9 && slv_cnt < 16) begin
        miso = slv_p[3'(15 - slv_cnt)];
      end
      if (slv_cnt == 8 && !sclk) slv_gap++;
      if (((slv_cnt == 8 && !sclk) || slv_cnt > 8) && mosi) mosi_err++;
    end
    sclk_q = sclk;
    cs_q   = cs;
  end

  // One transfer starting at the current negedge; returns at the done cycle
  task automatic xfer(input logic [3:0] ta, input logic [3:0] tbv, input int inj, output int lat);
    int cshi;
    start = 1'b1; a = ta; b = tbv;
    sb.push_back(8'(ta) * 8'(tbv));
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    cshi  = 0;
    check_eq("cs_fall", {31'd0, cs}, 32'd0);
    check_eq("busy_set", {31'd0, busy}, 32'd1);
    while (!done && lat < LATENCY + 100) begin
      if (cs) cshi++;
      if (lat == 2) begin a = ~ta; b = ~tbv; end
      if (lat == inj) begin start = 1'b1; a = 4'd1; b = 4'd1; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check_eq("done_seen", {31'd0, done}, 32'd1);
    check_eq("latency", lat, LATENCY);
    check_eq("cs_held_low", cshi, 0);
    check_eq("busy_clear", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int nd;
    int gap;
    reset = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0;

    // reset, with a start coincident with reset on the last cycle
    repeat (2) @(negedge clk);
    start = 1'b1; a = 4'd7; b = 4'd7;
    @(negedge clk);
    check_eq("rst_cs",     {31'd0, cs},   32'd1);
    check_eq("rst_sclk",   {31'd0, sclk}, 32'd0);
    check_eq("rst_mosi",   {31'd0, mosi}, 32'd0);
    check_eq("rst_result", {24'd0, result}, 32'd0);
    check_eq("rst_busy",   {31'd0, busy}, 32'd0);
    check_eq("rst_done",   {31'd0, done}, 32'd0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check_eq("start_in_reset_ignored", {31'd0, busy}, 32'd0);
    check_eq("start_in_reset_cs", {31'd0, cs}, 32'd1);
    repeat (3) @(negedge clk);

    // write waveform and first round trip
    xfer(4'd3, 4'd5, -1, lat);
    check_eq("mosi_byte", {24'd0, slv_wr}, 32'h53);
    check_eq("total_rises", slv_cnt, 16);
    check_eq("wait_low_cycles", slv_gap, WAIT_CYCLES + CLKDIV);
    @(negedge clk);
    check_eq("done_one_cycle", {31'd0, done}, 32'd0);
    check_eq("cs_idle", {31'd0, cs}, 32'd1);

    xfer(4'd15, 4'd15, -1, lat);
    @(negedge clk);
    xfer(4'd0, 4'd9, -1, lat);
    @(negedge clk);

    // start while busy, mid-write
    nd = n_done;
    xfer(4'd3, 4'd5, 60, lat);
    repeat (20) @(negedge clk);
    check_eq("single_done", n_done - nd, 1);

    // reset during read bit 4
    start = 1'b1; a = 4'd6; b = 4'd3;
    sb.push_back(8'd18);
    @(negedge clk);
    start = 1'b0;
    repeat (219) @(negedge clk);
    nd = n_done;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("midrst_cs",     {31'd0, cs},   32'd1);
    check_eq("midrst_sclk",   {31'd0, sclk}, 32'd0);
    check_eq("midrst_busy",   {31'd0, busy}, 32'd0);
    check_eq("midrst_result", {24'd0, result}, 32'd0);
    check_eq("midrst_done",   {31'd0, done}, 32'd0);
    sb.delete();
    repeat (300) @(negedge clk);
    check_eq("midrst_no_done", n_done - nd, 0);
    xfer(4'd2, 4'd7, -1, lat);
    @(negedge clk);

    // back-to-back: start on the cycle after done
    xfer(4'd9, 4'd13, -1, lat);
    gap = int'(cs);
    @(negedge clk);
    gap += int'(cs);
    xfer(4'd12, 4'd11, -1, lat);
    check_eq("b2b_cs_gap", gap, 1);
    @(negedge clk);

    check_eq("mosi_low_after_write", mosi_err, 0);
    check_eq("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/spi_mult_master.md
# spi_mult_master

SPI controller that drives the multiplier peripheral from the host side. On a `start` pulse it asserts chip select and shifts one operand byte `{b,a}` out on MOSI. It then waits a fixed number of clocks for the peripheral to multiply, and shifts the 8-bit product back in on MISO. It sits in the host-side test/SoC fabric and owns SCLK, CS and MOSI toward the peripheral.

## Interface
- `CLKDIV`, default 8: SCLK half-period in `clk` cycles, ≥2. Must exceed the peripheral's input-conditioner delay.
- `WAIT_CYCLES`, default 16: `clk` cycles SCLK is held low between the write and read phases, ≥1.
- `clk` input 1: system clock, the only clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: one-cycle request, accepted only when `busy`=0.
- `a` input 4: operand A, sent as the low nibble.
- `b` input 4: operand B, sent as the high nibble.
- `miso` input 1: serial data from the peripheral.
- `sclk` output 1: SPI clock, idles low.
- `cs` output 1: chip select, active-low, idles high.
- `mosi` output 1: serial data to the peripheral.
- `result` output 8: last received product, held until the next transfer completes.
- `busy` output 1: high from the cycle after `start` is accepted until `done`.
- `done` output 1: one-cycle pulse when `result` is updated.

## Operation
- Reset values: `cs`=1, `sclk`=0, `mosi`=0, `result`=0, `busy`=0, `done`=0, state IDLE.
- Internal blocks:
  - Divider counter 0..CLKDIV-1.
  - Bit counter 0..7.
  - 8-bit TX shift register.
  - 8-bit RX shift register.
  - Wait counter.
- IDLE: `cs`=1, `sclk`=0.
  - On `start`, latch TX = {b,a}, set `busy`=1, and go to SETUP.
  - `start` is ignored while `busy`=1.
- SETUP, CLKDIV cycles:
  - `cs`=0 and `mosi`=TX[7].
  - Then go to WRITE with bit count 0.
- WRITE, 8 bits, MSB first:
  - Each bit is CLKDIV cycles `sclk`=0, then CLKDIV cycles `sclk`=1.
  - `mosi` changes only on the cycle `sclk` falls, or on SETUP entry for bit 7. The peripheral samples on SCLK rise.
  - After the 8th high phase: `sclk`→0, `mosi`→0, go to WAIT.
- WAIT: `cs`=0, `sclk`=0 for WAIT_CYCLES cycles, then go to READ.
- READ, 8 bits:
  - Same SCLK waveform as WRITE, `mosi`=0.
  - `miso` is sampled into RX LSB-first-shift (RX <= {RX[6:0], miso}) on the last `clk` of each SCLK high phase, i.e. the cycle before `sclk` falls. First received bit = product MSB.
  - After the 8th high phase: `sclk`→0, go to FINISH.
- FINISH, 1 cycle:
  - `cs`→1, `result` <= RX, `done`=1, `busy`→0.
  - Return to IDLE. A new `start` may be accepted on the cycle after `done`.
- Reset mid-operation wins over everything:
  - Next cycle `cs`=1, `sclk`=0, `busy`=0 and counters cleared.
  - `result` is cleared to 0 and no `done` pulse is produced.
- `start` coincident with `reset`: ignored.
- Operands `a`/`b` are sampled only at acceptance. Later changes do not affect the transfer.

## Timing
- SCLK period is 2·CLKDIV clocks. Duty is exactly 50%. No glitches: `sclk` is a registered output.
- `cs` falls the cycle after `start` is accepted. It stays low continuously through SETUP, WRITE, WAIT and READ.
- Latency, from `start` accepted (cycle 0) to `done`:
  - Formula: CLKDIV + 16·CLKDIV + WAIT_CYCLES + 16·CLKDIV + 1.
  - Defaults: 8 + 128 + 16 + 128 + 1 = 281 cycles.
- First SCLK rising edge occurs 2·CLKDIV cycles after `cs` falls.
- `mosi` is stable for ≥CLKDIV cycles on each side of every SCLK rise.
- `done` is high for exactly one cycle. `result` is valid from the `done` cycle onward.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset check: assert `reset` 3 cycles. Required: `cs`=1, `sclk`=0, `mosi`=0, `result`=0, `busy`=0, `done`=0.
- Write waveform: `a`=3, `b`=5, `start`.
  - MOSI bits captured at SCLK rises = 0x53 (0,1,0,1,0,0,1,1).
  - Exactly 8 rises before WAIT.
  - SCLK low for 16 cycles during WAIT.
- Round-trip product: use a behavioral slave model that returns a·b MSB first.
  - a=3, b=5 → `result`=0x0F, `done` at cycle 281.
  - a=15, b=15 → `result`=0xE1.
  - a=0, b=9 → `result`=0x00.
- Start while busy: pulse `start` with a=1, b=1 mid-WRITE.
  - Transfer continues with the original operands.
  - Only one `done` pulse is produced, and `cs` is never re-asserted.
- Reset mid-READ: assert `reset` during bit 4.
  - Next cycle: `cs`=1, `sclk`=0, `busy`=0, `result`=0.
  - No `done` pulse.
  - A subsequent start with a=2, b=7 yields `result`=0x0E.
- Back-to-back: assert `start` on the cycle after `done`.
  - Accepted; `cs` rises for exactly 1 cycle between transfers.
  - Both results are correct.
